// File: rtl/hazard_pkg.sv
// Shared types and sizing for the hazard scoreboard: pipeline slot record and bubble constant.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      wr;
    logic      is_load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: '0, wr: 1'b0, is_load: 1'b0};

  // x0 is hardwired zero, so a write to it never produces a tracked result.
  function automatic logic tracks_write(logic rd_write, reg_addr_t rd);
    return rd_write && (rd != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side request, pipeline control and forwarding qualifiers of the hazard scoreboard.
// Perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_scoreboard_if;
  import hazard_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1_addr;
  reg_addr_t id_rs2_addr;
  logic      id_rs1_used;
  logic      id_rs2_used;
  reg_addr_t id_rd_addr;
  logic      id_rd_write;
  logic      id_is_load;
  logic      flush;
  logic      mem_wait;

  logic      stall_id;
  logic      bubble_exe;
  logic      exe_mem_fwd_write;
  reg_addr_t exe_mem_rd_addr;
  logic      mem_wb_fwd_write;
  reg_addr_t mem_wb_rd_addr;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_load_use_cnt;
  logic [31:0] perf_mem_wait_cnt;
`endif

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_write, id_is_load, flush, mem_wait,
    input  stall_id, bubble_exe, exe_mem_fwd_write, exe_mem_rd_addr,
           mem_wb_fwd_write, mem_wb_rd_addr
`ifdef HAZARD_PERF_EN
    , input perf_load_use_cnt, perf_mem_wait_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_write, id_is_load, flush, mem_wait,
    output stall_id, bubble_exe, exe_mem_fwd_write, exe_mem_rd_addr,
           mem_wb_fwd_write, mem_wb_rd_addr
`ifdef HAZARD_PERF_EN
    , output perf_load_use_cnt, perf_mem_wait_cnt
`endif
  );

endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating 32-bit event counter with enable; sticks at all-ones.
module hazard_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (en && (count_reg != '1)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks rd state of the EXE/MEM/WB slots, drives forward qualifiers and resolves load-use stalls.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);

  slot_t exe_slot_reg;
  slot_t mem_slot_reg;
  slot_t wb_slot_reg;
  slot_t exe_slot_next;
  slot_t id_slot;
  logic  rs1_hit;
  logic  rs2_hit;
  logic  load_use;

  assign id_slot = '{valid:   1'b1,
                     rd:      bus.id_rd_addr,
                     wr:      tracks_write(bus.id_rd_write, bus.id_rd_addr),
                     is_load: bus.id_is_load};

  assign rs1_hit  = bus.id_rs1_used && (bus.id_rs1_addr == exe_slot_reg.rd);
  assign rs2_hit  = bus.id_rs2_used && (bus.id_rs2_addr == exe_slot_reg.rd);
  assign load_use = bus.id_valid && exe_slot_reg.valid && exe_slot_reg.is_load &&
                    exe_slot_reg.wr && (rs1_hit || rs2_hit);

  assign bus.stall_id   = bus.mem_wait || (load_use && !bus.flush);
  assign bus.bubble_exe = load_use && !bus.mem_wait && !bus.flush;

  always_comb begin
    exe_slot_next = SLOT_BUBBLE;
    if (bus.id_valid && !bus.flush && !load_use) begin
      exe_slot_next = id_slot;
    end
  end

  // mem_wait freezes every slot; flush and load_use only matter when the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_slot_reg <= SLOT_BUBBLE;
      mem_slot_reg <= SLOT_BUBBLE;
      wb_slot_reg  <= SLOT_BUBBLE;
    end else if (!bus.mem_wait) begin
      wb_slot_reg  <= mem_slot_reg;
      mem_slot_reg <= exe_slot_reg;
      exe_slot_reg <= exe_slot_next;
    end
  end

  // Load data is not available until after MEM, so a load in EXE/MEM never forwards.
  assign bus.exe_mem_fwd_write = mem_slot_reg.valid && mem_slot_reg.wr && !mem_slot_reg.is_load;
  assign bus.exe_mem_rd_addr   = mem_slot_reg.rd;
  assign bus.mem_wb_fwd_write  = wb_slot_reg.valid && wb_slot_reg.wr;
  assign bus.mem_wb_rd_addr    = wb_slot_reg.rd;

`ifdef HAZARD_PERF_EN
  logic [1:0]  perf_en;
  logic [31:0] perf_cnt [2];

  assign perf_en[0] = bus.bubble_exe;
  assign perf_en[1] = bus.mem_wait;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    hazard_perf_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (perf_en[gi]),
      .count (perf_cnt[gi])
    );
  end

  assign bus.perf_load_use_cnt = perf_cnt[0];
  assign bus.perf_mem_wait_cnt = perf_cnt[1];
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a queue-based pipeline model.
// Perf counters are checked too when HAZARD_PERF_EN is defined.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } ins_t;

  // Index 0 = EXE, 1 = MEM, 2 = WB
  ins_t pipe[$];
  int   checks = 0;
  int   errors = 0;
  int   n_bubble = 0;
  int   n_wait = 0;
  bit   last_stall;
  bit   last_bubble;

  function automatic ins_t nop();
    ins_t n;
    n.v = 0; n.rd = 0; n.wr = 0; n.ld = 0;
    return n;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(nop());
    n_bubble = 0;
    n_wait = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit w, input bit ld, input bit fl, input bit mw);
    bus.id_valid    = v;
    bus.id_rs1_addr = 5'(rs1);
    bus.id_rs1_used = u1;
    bus.id_rs2_addr = 5'(rs2);
    bus.id_rs2_used = u2;
    bus.id_rd_addr  = 5'(rd);
    bus.id_rd_write = w;
    bus.id_is_load  = ld;
    bus.flush       = fl;
    bus.mem_wait    = mw;
  endtask

  task automatic check_outputs(input string tag);
    bit lu;
    ins_t ex;
    ex = pipe[0];
    lu = bus.id_valid && ex.v && ex.ld && ex.wr &&
         ((bus.id_rs1_used && int'(bus.id_rs1_addr) == ex.rd) ||
          (bus.id_rs2_used && int'(bus.id_rs2_addr) == ex.rd));
    last_stall  = bus.mem_wait || (lu && !bus.flush);
    last_bubble = lu && !bus.mem_wait && !bus.flush;
    chk({tag, ".stall_id"},   32'(bus.stall_id),   32'(last_stall));
    chk({tag, ".bubble_exe"}, 32'(bus.bubble_exe), 32'(last_bubble));
    chk({tag, ".em_fwd"},  32'(bus.exe_mem_fwd_write), 32'(pipe[1].v && pipe[1].wr && !pipe[1].ld));
    chk({tag, ".em_rd"},   32'(bus.exe_mem_rd_addr),   32'(pipe[1].rd));
    chk({tag, ".mw_fwd"},  32'(bus.mem_wb_fwd_write),  32'(pipe[2].v && pipe[2].wr));
    chk({tag, ".mw_rd"},   32'(bus.mem_wb_rd_addr),    32'(pipe[2].rd));
`ifdef HAZARD_PERF_EN
    chk({tag, ".perf_lu"}, bus.perf_load_use_cnt, 32'(n_bubble));
    chk({tag, ".perf_mw"}, bus.perf_mem_wait_cnt, 32'(n_wait));
`endif
  endtask

  // Check settled outputs, advance the model as the clock edge will, then move to the next negedge.
  task automatic step(input string tag);
    ins_t n;
    #1;
    check_outputs(tag);
    if (!bus.mem_wait) begin
      n = nop();
      if (bus.id_valid && !bus.flush && !last_stall) begin
        n.v  = 1;
        n.rd = int'(bus.id_rd_addr);
        n.wr = bus.id_rd_write && (bus.id_rd_addr != 0);
        n.ld = bus.id_is_load;
      end
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    if (last_bubble) n_bubble++;
    if (bus.mem_wait) n_wait++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("idle");
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // ALU chain: add x5 then sub reading x5
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); step("alu_add");
    drive(1, 5, 1, 3, 1, 6, 1, 0, 0, 0); step("alu_sub");
    chk("alu_em_fwd", 32'(bus.exe_mem_fwd_write), 32'd1);
    chk("alu_em_rd", 32'(bus.exe_mem_rd_addr), 32'd5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("alu_idle");
    chk("alu_mw_fwd", 32'(bus.mem_wb_fwd_write), 32'd1);
    chk("alu_mw_rd", 32'(bus.mem_wb_rd_addr), 32'd5);
    idle(2);

    // Load-use: lw x7, then add reading rs2=x7
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); step("lu_load");
    drive(1, 2, 1, 7, 1, 8, 1, 0, 0, 0); step("lu_stall");
    chk("lu_stall_seen", 32'(last_stall), 32'd1);
    step("lu_repres");
    chk("lu_load_em_noforward", 32'(bus.exe_mem_fwd_write), 32'd0);
    chk("lu_load_mw_fwd", 32'(bus.mem_wb_fwd_write), 32'd1);
    chk("lu_load_mw_rd", 32'(bus.mem_wb_rd_addr), 32'd7);
    idle(3);

    // x0 load and unused source never stall
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0); step("x0_load");
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0, 0); step("x0_use");
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); step("unused_load");
    drive(1, 7, 0, 3, 1, 9, 1, 0, 0, 0); step("unused_use");
    idle(3);

    // mem_wait for 3 cycles with lw x9 in MEM
    drive(1, 1, 1, 0, 0, 9, 1, 1, 0, 0); step("mw_load");
    drive(1, 2, 1, 3, 1, 4, 1, 0, 0, 0); step("mw_next");
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 1, 9, 1, 10, 1, 0, 0, 1); step("mw_hold");
    end
    drive(1, 9, 1, 9, 1, 10, 1, 0, 0, 0); step("mw_release");
    idle(3);

    // flush coincident with load_use
    drive(1, 1, 1, 0, 0, 12, 1, 1, 0, 0); step("fl_load");
    drive(1, 12, 1, 0, 0, 13, 1, 0, 1, 0); step("fl_lu");
    idle(3);

    // Async reset while a load-use stall is pending
    drive(1, 1, 1, 0, 0, 14, 1, 1, 0, 0); step("rst_load");
    drive(1, 14, 1, 0, 0, 15, 1, 0, 0, 0);
    #1;
    check_outputs("rst_pre");
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer side of the forwarding path.
- Tracks destination-register state of the in-flight instructions in the EXE, MEM and WB slots.
- Drives the EXE/MEM and MEM/WB forward-write qualifiers and rd addresses that the forwarding selector consumes.
- Detects load-use hazards, stalls ID and injects EXE bubbles; honours memory wait and branch flush.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, architectural register count; x0 is hardwired zero.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1_addr  in  REG_ADDR_W  ID source 1
- id_rs2_addr  in  REG_ADDR_W  ID source 2
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd_addr  in  REG_ADDR_W  ID destination
- id_rd_write  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load (result available after MEM)
- flush  in  1  branch/jump redirect; squash the ID instruction
- mem_wait  in  1  data memory not ready; freeze EXE/MEM/WB
- stall_id  out  1  hold PC and IF/ID
- bubble_exe  out  1  NOP inserted into EXE this cycle
- exe_mem_fwd_write  out  1  EXE/MEM slot holds forwardable result
- exe_mem_rd_addr  out  REG_ADDR_W  EXE/MEM slot destination
- mem_wb_fwd_write  out  1  MEM/WB slot writes register file
- mem_wb_rd_addr  out  REG_ADDR_W  MEM/WB slot destination

Behaviour:
- Three slot registers: EXE, MEM, WB. Each holds {valid, rd, wr, is_load}.
- rst (async): all slots cleared to valid=0, rd=0, wr=0, is_load=0. All outputs read 0 during and after reset until a valid instruction is captured.
- Capture into EXE: wr = id_rd_write && (id_rd_addr != 0). x0 writes are never tracked.
- load_use = id_valid && EXE.valid && EXE.is_load && EXE.wr && ((id_rs1_used && id_rs1_addr == EXE.rd) || (id_rs2_used && id_rs2_addr == EXE.rd)).
- stall_id = mem_wait || (load_use && !flush). Combinational.
- bubble_exe = load_use && !mem_wait && !flush.
- Each clock edge, priority order:
  - mem_wait=1: all slots hold. flush and load_use are ignored; flush must be held by the upstream until mem_wait drops.
  - else flush=1: WB<=MEM, MEM<=EXE, EXE<=bubble.
  - else load_use: shift as above, EXE<=bubble. ID instruction is re-presented next cycle.
  - else: shift; EXE <= id_valid ? ID fields : bubble.
- Outputs are combinational from slot registers only, with no input-to-output path:
  - exe_mem_fwd_write = MEM.valid && MEM.wr && !MEM.is_load (load data cannot forward from EXE/MEM).
  - exe_mem_rd_addr = MEM.rd.
  - mem_wb_fwd_write = WB.valid && WB.wr.
  - mem_wb_rd_addr = WB.rd.
- Latency: a single load-use costs exactly one bubble. After the bubble, the load is in MEM and the consumer stays in ID. Next cycle the load is in WB, so the MEM/WB forward covers it.
- Back-to-back loads to the same rd: each is handled independently per slot.
- rst asserted mid-stall: all slots clear immediately and stall_id drops unless mem_wait=1.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_load_use_cnt (32) and perf_mem_wait_cnt (32).
  - perf_load_use_cnt increments on cycles with bubble_exe=1; perf_mem_wait_cnt increments on cycles with mem_wait=1.
  - Both saturate at all-ones and are cleared by rst.
- When undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_ADDR_W and NUM_REGS.
  - typedef slot_t {valid, rd, wr, is_load}.
  - constant SLOT_BUBBLE.
- Sub-module hazard_perf_counter: saturating 32-bit counter with enable, instantiated twice under HAZARD_PERF_EN.
- All other logic is flat in hazard_scoreboard.

Test Plan:
- Reset: assert rst mid-cycle with slots populated -> all outputs 0 immediately; stall_id=0.
- ALU chain: issue add x5; then sub using rs1=x5 -> next cycle exe_mem_fwd_write=1, exe_mem_rd_addr=5; following cycle mem_wb_fwd_write=1, mem_wb_rd_addr=5; no stall.
- Load-use: issue lw x7; then add rs2=x7, rs2_used=1 -> stall_id=1 and bubble_exe=1 for exactly one cycle. Next cycle mem_wb_fwd_write=0 and exe_mem_fwd_write=0 for the load. Cycle after: mem_wb_fwd_write=1, rd=7.
- x0 and unused source: lw x0 followed by a use of x0 -> no stall; lw x7 followed by an instruction with rs1=x7 but rs1_used=0 -> no stall.
- mem_wait: hold mem_wait=1 for 3 cycles with lw x9 in MEM -> all slot outputs frozen, stall_id=1 throughout, bubble_exe=0. On release the pipeline resumes shifting.
- flush with load_use: flush=1 in the same cycle as load_use -> stall_id=0, bubble_exe=0, EXE receives bubble. Under HAZARD_PERF_EN, perf_load_use_cnt is unchanged.
